// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Brief  : Access-size encodings and controller state encoding for data_mem_sync.
// Rev    : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : dmem_lane_align
// Brief  : Little-endian store lane steering and load extraction/extension.
// Rev    : 1.0
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wbe,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rword[{lane, 3'b000} +: 8];
    assign w_half = rword[{lane[1], 4'b0000} +: 16];

    always_comb begin
        wbe   = 4'b0000;
        wword = wdata;
        ldata = rword;
        case (size)
            SZ_BYTE: begin
                wbe   = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
                ldata = {{24{sext & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                wbe   = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                ldata = {{16{sext & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                wbe   = 4'b1111;
            end
            default: begin
                wbe   = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_sync.sv
`default_nettype none
// ============================================================================
// Module : data_mem_sync
// Brief  : Single-port 32-bit data memory with byte/half/word access and
//          programmable load latency; stores commit on the accept edge.
// Rev    : 1.0
// ============================================================================
module data_mem_sync
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int         IDXW      = $clog2(DEPTH);
    localparam logic [1:0] WAIT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              fault_q, fault_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              sext_q, sext_d;

    logic [31:0]       mem [DEPTH];

    logic              w_accept;
    logic              w_fault;
    logic              w_in_wait;
    logic              w_wr_en;
    logic [IDXW-1:0]   w_idx;
    logic [IDXW-1:0]   w_sel_idx;
    logic [1:0]        w_sel_size;
    logic [1:0]        w_sel_lane;
    logic              w_sel_sext;
    logic [31:0]       w_rword;
    logic [3:0]        w_wbe;
    logic [31:0]       w_wword;
    logic [31:0]       w_ldata;

    assign w_accept  = req & ready_q;
    assign w_idx     = addr[IDXW+1:2];
    assign w_fault   = (size == SZ_ILLEGAL)
                     | ((size == SZ_HALF) & addr[0])
                     | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
                     | (|addr[31:IDXW+2]);
    assign w_wr_en   = w_accept & we & ~w_fault;

    // A pending multi-cycle load reads through its captured fields; otherwise
    // the live request drives the datapath so LAT=1 loads complete on accept.
    assign w_in_wait  = (state_q == ST_WAIT);
    assign w_sel_idx  = w_in_wait ? idx_q  : w_idx;
    assign w_sel_size = w_in_wait ? size_q : size;
    assign w_sel_lane = w_in_wait ? lane_q : addr[1:0];
    assign w_sel_sext = w_in_wait ? sext_q : sext;
    assign w_rword    = mem[w_sel_idx];

    dmem_lane_align u_align (
        .size  (w_sel_size),
        .sext  (w_sel_sext),
        .lane  (w_sel_lane),
        .wdata (wdata),
        .rword (w_rword),
        .wbe   (w_wbe),
        .wword (w_wword),
        .ldata (w_ldata)
    );

    always_comb begin
        state_d  = state_q;
        rvalid_d = 1'b0;
        fault_d  = 1'b0;
        rdata_d  = 32'd0;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        size_d   = size_q;
        lane_d   = lane_q;
        sext_d   = sext_q;
        if (w_in_wait) begin
            if (cnt_q == 2'd0) begin
                state_d  = ST_RESP;
                rvalid_d = 1'b1;
                rdata_d  = w_ldata;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (w_accept) begin
            idx_d  = w_idx;
            size_d = size;
            lane_d = addr[1:0];
            sext_d = sext;
            if (w_fault || we || (LAT == 1)) begin
                state_d  = ST_RESP;
                rvalid_d = 1'b1;
                fault_d  = w_fault;
                rdata_d  = (w_fault || we) ? 32'd0 : w_ldata;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_INIT;
            end
        end else begin
            state_d = ST_IDLE;
        end
        ready_d = (state_d != ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
            cnt_q    <= 2'd0;
            idx_q    <= '0;
            size_q   <= SZ_BYTE;
            lane_q   <= 2'd0;
            sext_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            size_q   <= size_d;
            lane_q   <= lane_d;
            sext_q   <= sext_d;
        end
    end

    // Array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wbe[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_sync.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_sync
// Brief  : Directed vectors and randomized traffic against a byte-array model,
//          on one LAT=1 and one LAT=3 instance.
// Rev    : 1.0
// ============================================================================
module tb_data_mem_sync;

    localparam int DEPTH = 128;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n, req, we, sext, sel;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        req1, req3;
    logic        ready1, rvalid1, fault1, ready3, rvalid3, fault3;
    logic [31:0] rdata1, rdata3;
    logic        ready, rvalid, fault;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    assign req1   = req & ~sel;
    assign req3   = req & sel;
    assign ready  = sel ? ready3  : ready1;
    assign rvalid = sel ? rvalid3 : rvalid1;
    assign fault  = sel ? fault3  : fault1;
    assign rdata  = sel ? rdata3  : rdata1;

    data_mem_sync #(.DEPTH(DEPTH), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .ready(ready1), .rvalid(rvalid1),
        .rdata(rdata1), .fault(fault1)
    );

    data_mem_sync #(.DEPTH(DEPTH), .LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .ready(ready3), .rvalid(rvalid3),
        .rdata(rdata3), .fault(fault3)
    );

    int checks = 0;
    int errors = 0;
    bit [7:0] mb [2][NBYTE];

    typedef struct {
        bit        w;
        bit [1:0]  sz;
        bit        s;
        bit [31:0] a;
        bit [31:0] wd;
        bit        ef;
        bit [31:0] erd;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mdl_fault(input bit [1:0] sz, input bit [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
               (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'(NBYTE));
    endfunction

    function automatic bit [31:0] mdl_load(input int d, input bit [1:0] sz, input bit s, input bit [31:0] a);
        int nb = 1 << sz;
        bit [31:0] v = 32'd0;
        for (int i = 0; i < nb; i++) v |= 32'(mb[d][int'(a) + i]) << (8 * i);
        if (s && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    task automatic mdl_store(input int d, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
    endtask

    // Starts and ends at a falling edge; the next call is therefore accepted in RESP.
    task automatic access(input bit w, input bit [1:0] sz, input bit s, input bit [31:0] a,
                          input bit [31:0] wd, input bit ef, input bit [31:0] erd, input string tag);
        int lat;
        chk({tag, " ready_at_issue"}, 32'(ready), 32'd1);
        we = w; size = sz; sext = s; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        if (w && !mdl_fault(sz, a)) mdl_store(int'(sel), sz, a, wd);
        lat = (ef || w) ? 1 : (sel ? 3 : 1);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                chk({tag, " rvalid_in_wait"}, 32'(rvalid), 32'd0);
                chk({tag, " ready_in_wait"}, 32'(ready), 32'd0);
            end else begin
                chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
                chk({tag, " fault"}, 32'(fault), 32'(ef));
                chk({tag, " rdata"}, rdata, erd);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle rvalid", 32'(rvalid), 32'd0);
            chk("idle ready", 32'(ready), 32'd1);
        end
    endtask

    initial begin
        bit        w, s, ef;
        bit [1:0]  sz;
        bit [31:0] a, wd, erd;

        req = 0; we = 0; size = 0; sext = 0; addr = 0; wdata = 0; sel = 0; rst_n = 0;

        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h28,  32'h5AA55AA5, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h28,  32'h0,        1'b0, 32'h5AA55AA5});
        tbl.push_back('{1'b0, 2'd2, 1'b1, 32'h28,  32'h0,        1'b0, 32'h5AA55AA5});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h2C,  32'h778877F0, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h2C,  32'h0,        1'b0, 32'hFFFFFFF0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h2C,  32'h0,        1'b0, 32'h000000F0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h2E,  32'h0,        1'b0, 32'h00007788});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h2E,  32'h0,        1'b0, 32'hFFFFFF88});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h2D,  32'h0,        1'b0, 32'h00000077});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h2C,  32'h0,        1'b0, 32'h000077F0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h0,   32'h11223344, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h1,   32'hFFFFFFAB, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        1'b0, 32'h1122AB44});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h0,   32'h0,        1'b0, 32'hFFFFAB44});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h3,   32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h202, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h1,   32'hDEADBEEF, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h4,   32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h0,   32'hDEADBEEF, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        1'b0, 32'h1122AB44});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h2,   32'h1234C0DE, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        1'b0, 32'hC0DEAB44});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h2,   32'h0,        1'b0, 32'hFFFFC0DE});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h3,   32'h0,        1'b0, 32'h000000C0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h1FC, 32'h80000001, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h1FF, 32'h0,        1'b0, 32'hFFFFFF80});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        1'b0, 32'h80000001});

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            chk("reset ready", 32'(ready), 32'd1);
            chk("reset rvalid", 32'(rvalid), 32'd0);
            chk("reset fault", 32'(fault), 32'd0);
            chk("reset rdata", rdata, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the LAT=1 instance, issued back-to-back.
        for (int i = 0; i < tbl.size(); i++) begin
            access(tbl[i].w, tbl[i].sz, tbl[i].s, tbl[i].a, tbl[i].wd, tbl[i].ef, tbl[i].erd,
                   $sformatf("vec%0d", i));
        end
        idle(2);

        // LAT=3 instance: back-to-back loads accepted in RESP.
        sel = 1'b1;
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0, "lat3 st");
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D, "lat3 ld0");
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D, "lat3 ld1");
        access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFCAFE, "lat3 ldh");
        access(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, "lat3 flt");
        idle(2);

        // Reset pulse while a LAT=3 load sits in WAIT.
        we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h10; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("abort ready_in_wait", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort ready_in_reset", 32'(ready), 32'd1);
        chk("abort rvalid_in_reset", 32'(rvalid), 32'd0);
        #1 rst_n = 1'b1;
        idle(4);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, mdl_load(1, 2'd2, 1'b0, 32'h10), "after abort");
        idle(1);

        // Randomized traffic on both instances after filling every word.
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            for (int i = 0; i < DEPTH; i++) begin
                access(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 1'b0, 32'h0, "fill");
            end
            for (int n = 0; n < 250; n++) begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                s  = 1'($urandom_range(0, 1));
                a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NBYTE - 1));
                wd = $urandom;
                ef = mdl_fault(sz, a);
                erd = (ef || w) ? 32'h0 : mdl_load(d, sz, s, a);
                access(w, sz, s, a, wd, ef, erd, $sformatf("rnd%0d_%0d", d, n));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 128, SHALL set the number of 32-bit words (power of two, 16..4096).
REQ-003 Parameter LAT, default 1, SHALL set the read latency in cycles from accept to rvalid (range 1..4).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  1  access request, sampled with ready.
REQ-007 we  in  1  1 = store, 0 = load.
REQ-008 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 sext  in  1  sign-extend load result (byte/half only).
REQ-010 addr  in  32  byte address.
REQ-011 wdata  in  32  store data, right-aligned (bits [7:0] byte, [15:0] half).
REQ-012 ready  out  1  block can accept a request this cycle.
REQ-013 rvalid  out  1  one-cycle response pulse (load data or store ack).
REQ-014 rdata  out  32  load result; 0 for store acks and faults.
REQ-015 fault  out  1  qualifies rvalid: access rejected.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; ready SHALL be 1 in IDLE and RESP, 0 in WAIT.
REQ-017 A request SHALL be accepted on a rising edge with req=1 and ready=1; req while ready=0 SHALL be ignored, with no queuing.
REQ-018 On accept, addr, we, size, sext and wdata SHALL be captured.
REQ-019 Word index SHALL be addr[log2(DEPTH)+1:2]; nonzero addr bits above that field SHALL fault.
REQ-020 Faults SHALL be: size=11; half with addr[0]=1; word with addr[1:0]!=0; out-of-range address.
REQ-021 Faulted accesses SHALL NOT modify memory; the FSM SHALL go to RESP, and the next cycle SHALL give rvalid=1, fault=1, rdata=0.
REQ-022 A legal store SHALL write only the addressed byte lanes on the accept edge (little-endian: byte lane addr[1:0], half lane addr[1]).
REQ-023 A store SHALL go to RESP with rvalid=1, fault=0, rdata=0 the next cycle, independent of LAT.
REQ-024 A legal load SHALL go IDLE->RESP when LAT=1, or IDLE->WAIT for LAT-1 cycles then RESP; rvalid SHALL assert exactly LAT cycles after accept.
REQ-025 Load data SHALL be shifted from the addressed lane to bit 0, then zero-extended (sext=0) or sign-extended (sext=1); word loads SHALL ignore sext.
REQ-026 A load of a word stored in an earlier accepted request SHALL return the new value (no stale data).
REQ-027 A request accepted in RESP SHALL start back-to-back; rvalid SHALL be 1 for exactly one cycle per accepted request.
REQ-028 With no accept in RESP, the FSM SHALL return to IDLE and rvalid SHALL drop to 0.
REQ-029 Memory contents SHALL be undefined until written and SHALL NOT be cleared by reset.

Reset
REQ-030 While rst_n=0, the block SHALL be in state IDLE, with rvalid=0, fault=0, rdata=0 and ready=1.
REQ-031 Reset asserted mid-access SHALL abort it with no rvalid; a store already committed on its accept edge SHALL persist.
REQ-032 The first accept SHALL occur on the first rising edge after rst_n deasserts with req=1.

Structure
REQ-033 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-034 Sub-module dmem_lane_align SHALL do the combinational work: store byte-enable/lane steering, and load extraction with zero/sign extension.
REQ-035 The top level SHALL hold the FSM, the latency counter, the request registers and the memory array.

Verification
REQ-036 Word store 0x5AA55AA5 at 0x28, then word load 0x28 (LAT=1) -> rvalid 1 cycle after load accept, rdata=0x5AA55AA5, fault=0.
REQ-037 Word 0x778877F0 at 0x2C, then byte loads at 0x2C with sext=1 and sext=0 -> 0xFFFFFFF0 and 0x000000F0; half load 0x2E sext=0 -> 0x00007788.
REQ-038 Word 0x11223344 at 0x0, byte store 0xAB at 0x1, word load 0x0 -> 0x1122AB44.
REQ-039 Half load 0x3, word load 0x202 (DEPTH=128), word load 0x200 -> each fault=1, rdata=0, memory unchanged.
REQ-040 LAT=3, back-to-back loads accepted in RESP -> rvalid 3 cycles after each accept, ready=0 during WAIT, one pulse per request.
REQ-041 rst_n pulsed low during WAIT of a load -> no rvalid, ready=1, a following load returns previously stored data.
